fifo_to_axis: RTL and testbench
===============================

FIFO_TO_AXIS -- requirements
Module: fifo_to_axis

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the FIFO read-data and m_axis_tdata width in bits.
REQ-002 SHALL have parameter PKT_LEN, default 256, meaning beats per packet for tlast generation; legal range is 1 to 65535.
REQ-003 SHALL have port rd_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rd_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port fifo_dout, input, DATA_WIDTH bits: FIFO read data, registered, valid on the cycle after an accepted read.
REQ-006 SHALL have port fifo_empty, input, 1 bit: FIFO empty flag, already synchronous to rd_clk.
REQ-007 SHALL have port fifo_rd_en, output, 1 bit: FIFO read request; the FIFO accepts it when fifo_empty=0.
REQ-008 SHALL have port m_axis_tdata, output, DATA_WIDTH bits: AXI-Stream data.
REQ-009 SHALL have port m_axis_tvalid, output, 1 bit: AXI-Stream valid.
REQ-010 SHALL have port m_axis_tready, input, 1 bit: AXI-Stream ready.
REQ-011 SHALL have port m_axis_tlast, output, 1 bit: last beat of a PKT_LEN-beat packet.

Function
REQ-012 SHALL hold a 2-entry in-order output buffer (head and tail), an occupancy count of 0 to 2, and a pending flag.
- The pending flag SHALL be set exactly when the previous cycle had fifo_rd_en=1 and fifo_empty=0.
REQ-013 SHALL define pop = m_axis_tvalid & m_axis_tready.
REQ-014 SHALL drive fifo_rd_en combinationally as !fifo_empty & ((count + pending - pop) < 2), so that count + pending never exceeds 2.
REQ-015 SHALL, when pending=1, write fifo_dout into the buffer at that clock edge.
- Target slot is head if the buffer is empty after pop, else tail.
REQ-016 SHALL drive m_axis_tvalid = (count != 0) and m_axis_tdata = head entry, both taken from registers with no combinational path from m_axis_tready.
REQ-017 SHALL hold m_axis_tdata, m_axis_tlast and m_axis_tvalid stable while m_axis_tvalid=1 and m_axis_tready=0 (AXI-Stream rule).
REQ-018 SHALL, on a simultaneous pop and capture, move the tail to the head and place the captured word behind it; count is unchanged and order is preserved.
REQ-019 SHALL, when already streaming, sustain 1 beat per cycle while fifo_empty=0 and m_axis_tready=1.
REQ-020 SHALL, when the buffer is empty, first assert m_axis_tvalid 2 rd_clk cycles after the cycle in which fifo_empty=0 is sampled.
- Cycle T: fifo_rd_en=1. Cycle T+1: data captured at the end of the cycle. Cycle T+2: tvalid=1.
REQ-021 SHALL keep a beat counter of width $clog2(PKT_LEN+1) bits, counting 0 to PKT_LEN-1; it increments on pop and wraps to 0 after a pop of the beat at PKT_LEN-1.
REQ-022 SHALL drive m_axis_tlast = m_axis_tvalid & (beat counter == PKT_LEN-1); with PKT_LEN=1, tlast is high on every valid beat.
REQ-023 SHALL never drop, duplicate or reorder a FIFO word while rd_rst_n=1.
REQ-024 SHALL, while fifo_empty=1, hold fifo_rd_en=0; any words already in the buffer still drain normally.

Reset
REQ-025 SHALL, while rd_rst_n=0, asynchronously force:
- count=0, pending=0, beat counter=0;
- m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0;
- fifo_rd_en=0, independent of fifo_empty.
REQ-026 SHALL, on reset assertion mid-operation, discard buffered and in-flight words; the FIFO pointer advance for a discarded in-flight read is not recovered.
REQ-027 SHALL release reset synchronously: the first fifo_rd_en is allowed in the first rd_clk cycle after rd_rst_n rises.

Verification
REQ-028 Single word: buffer empty, fifo_dout=0xA5A5A5A5 after the read, fifo_empty low for 1 cycle, tready=1 -> fifo_rd_en high 1 cycle; tvalid high exactly 1 cycle, 2 cycles later; tdata=0xA5A5A5A5.
REQ-029 Stream: 1000 words 0..999, tready=1, PKT_LEN=4 -> after 2-cycle fill, 1 beat per cycle, data in order; tlast on words 3, 7, ..., 999.
REQ-030 Backpressure: tready toggles in a random pattern, 500 words -> no loss or reorder; tdata/tlast stable while tvalid=1 and tready=0; count never exceeds 2.
REQ-031 Stall with full buffer: tready=0, fifo_empty=0 -> at most 2 reads issued, then fifo_rd_en=0 until the first pop.
REQ-032 Mid-stream reset: rd_rst_n low during beat 2 of a 4-beat packet -> all outputs 0 immediately; after release, the next beat has beat index 0 and tlast only on the 4th beat.
REQ-033 PKT_LEN=1: 10 words -> m_axis_tlast=1 on all 10 beats.

Source files
------------

// File: rtl/fifo_to_axis.sv
// Converts a registered-output FIFO read port into an AXI-Stream master with tlast every PKT_LEN beats.
// First beat appears 2 cycles after a non-empty FIFO is seen; a 2-entry skid buffer keeps 1 beat/cycle and never over-reads under backpressure.
module fifo_to_axis #(
    parameter int DATA_WIDTH = 32,
    parameter int PKT_LEN    = 256
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
);

    localparam int BW = $clog2(PKT_LEN + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] tail;
    logic [1:0]            count;
    logic                  pending;
    logic [BW-1:0]         beat;

    logic       pop;
    logic [1:0] count_ap;
    logic [2:0] occ;

    assign pop      = m_axis_tvalid & m_axis_tready;
    assign count_ap = count - {1'b0, pop};
    // Words already owned by this block (buffered plus the read still in flight) after this cycle's pop.
    assign occ      = {1'b0, count_ap} + {2'b00, pending};

    assign fifo_rd_en    = rd_rst_n & ~fifo_empty & (occ < 3'd2);
    assign m_axis_tvalid = (count != 2'd0);
    assign m_axis_tdata  = head;
    assign m_axis_tlast  = m_axis_tvalid & (beat == LAST_BEAT);

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            head    <= '0;
            tail    <= '0;
            count   <= 2'd0;
            pending <= 1'b0;
            beat    <= '0;
        end else begin
            pending <= fifo_rd_en;
            count   <= count_ap + {1'b0, pending};

            // Capture lands in the first free slot after the pop; a pop from a full buffer shifts tail forward.
            if (pending && (count_ap == 2'd0)) begin
                head <= fifo_dout;
            end else if (pop && (count == 2'd2)) begin
                head <= tail;
            end

            if (pending && (count_ap == 2'd1)) begin
                tail <= fifo_dout;
            end

            if (pop) begin
                beat <= (beat == LAST_BEAT) ? '0 : beat + BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_to_axis.sv
// Bench for fifo_to_axis: a queue-based FIFO and scoreboard model drive two instances (PKT_LEN 4 and 1).
module tb_fifo_to_axis;

    logic        rd_clk = 1'b0;
    logic        rd_rst_n;
    logic [31:0] fifo_dout;
    logic        fifo_empty;
    logic        m_axis_tready;

    logic        rd_en4, vld4, last4;
    logic        rd_en1, vld1, last1;
    logic [31:0] dat4, dat1;

    always #5 rd_clk = ~rd_clk;

    fifo_to_axis #(.DATA_WIDTH(32), .PKT_LEN(4)) dut4 (
        .rd_clk        (rd_clk),
        .rd_rst_n      (rd_rst_n),
        .fifo_dout     (fifo_dout),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (rd_en4),
        .m_axis_tdata  (dat4),
        .m_axis_tvalid (vld4),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (last4)
    );

    fifo_to_axis #(.DATA_WIDTH(32), .PKT_LEN(1)) dut1 (
        .rd_clk        (rd_clk),
        .rd_rst_n      (rd_rst_n),
        .fifo_dout     (fifo_dout),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (rd_en1),
        .m_axis_tdata  (dat1),
        .m_axis_tvalid (vld1),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (last1)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] fifo_q[$];   // words still inside the upstream FIFO
    logic [31:0] exp_q[$];    // words read from the FIFO and not yet delivered, oldest first
    int          vis_q[$];    // cycle at which each exp_q word may first be presented

    int cyc       = 0;
    int beats     = 0;
    int pop_cnt   = 0;
    int vld_cnt   = 0;
    int acc_cnt   = 0;
    int first_acc = -1;
    int first_pop = -1;
    int last_pop  = -1;
    int src_left  = 0;
    int push_prob = 100;
    int ready_prob = 100;
    bit rd_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        pop_cnt   = 0;
        vld_cnt   = 0;
        acc_cnt   = 0;
        first_acc = -1;
        first_pop = -1;
        last_pop  = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tvalid"}, {31'd0, vld4}, 32'd0);
        chk({tag, "_tlast"}, {31'd0, last4}, 32'd0);
        chk({tag, "_tdata"}, dat4, 32'd0);
        chk({tag, "_rd_en"}, {31'd0, rd_en4}, 32'd0);
        chk({tag, "_tlast_p1"}, {31'd0, last1}, 32'd0);
        chk({tag, "_rd_en_p1"}, {31'd0, rd_en1}, 32'd0);
    endtask

    // One clock cycle: check outputs mid-cycle, advance the model, then update inputs after the edge.
    task automatic step();
        bit          exp_vld;
        bit          pop_exp;
        bit          exp_rd;
        int          occ;
        logic [31:0] w;
        @(negedge rd_clk);
        cyc++;
        exp_vld = 1'b0;
        if (exp_q.size() > 0) exp_vld = (rd_rst_n === 1'b1) && (vis_q[0] <= cyc);
        chk("tvalid", {31'd0, vld4}, {31'd0, exp_vld});
        chk("tvalid_p1", {31'd0, vld1}, {31'd0, exp_vld});
        if (exp_vld) begin
            chk("tdata", dat4, exp_q[0]);
            chk("tdata_p1", dat1, exp_q[0]);
        end
        chk("tlast", {31'd0, last4}, {31'd0, exp_vld && (beats % 4 == 3)});
        chk("tlast_p1", {31'd0, last1}, {31'd0, exp_vld});
        pop_exp = exp_vld && (m_axis_tready === 1'b1);
        occ     = exp_q.size() - (pop_exp ? 1 : 0);
        exp_rd  = (rd_rst_n === 1'b1) && (fifo_empty === 1'b0) && (occ < 2);
        chk("rd_en", {31'd0, rd_en4}, {31'd0, exp_rd});
        chk("rd_en_p1", {31'd0, rd_en1}, {31'd0, exp_rd});
        if (vld4 === 1'b1) vld_cnt++;
        if (pop_exp) begin
            void'(exp_q.pop_front());
            void'(vis_q.pop_front());
            beats++;
            pop_cnt++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        rd_acc = exp_rd;
        if (rd_acc) begin
            acc_cnt++;
            if (first_acc < 0) first_acc = cyc;
        end
        @(posedge rd_clk);
        #1;
        if (rd_acc) begin
            w = fifo_q.pop_front();
            fifo_dout = w;
            exp_q.push_back(w);
            vis_q.push_back(cyc + 2);
        end
        if (src_left > 0 && $urandom_range(99) < push_prob) begin
            fifo_q.push_back($urandom);
            src_left--;
        end
        m_axis_tready = ($urandom_range(99) < ready_prob);
        fifo_empty    = (fifo_q.size() == 0);
    endtask

    task automatic drain(input int budget, input string tag);
        int n = 0;
        while ((fifo_q.size() > 0 || exp_q.size() > 0 || src_left > 0) && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_leftover"}, 32'(fifo_q.size() + exp_q.size() + src_left), 32'd0);
    endtask

    // Called just after a rising edge; buffered and in-flight words are lost.
    task automatic do_reset(input string tag);
        rd_rst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        exp_q.delete();
        vis_q.delete();
        beats = 0;
        step();
        step();
        rd_rst_n = 1'b1;
    endtask

    initial begin
        rd_rst_n      = 1'b0;
        fifo_dout     = 32'd0;
        fifo_empty    = 1'b0;
        m_axis_tready = 1'b1;
        #2;
        check_reset_outputs("por");
        @(posedge rd_clk);
        #1;
        rd_rst_n   = 1'b1;
        fifo_empty = 1'b1;

        // Single word with an idle buffer.
        clear_stats();
        fifo_q.push_back(32'hA5A5_A5A5);
        fifo_empty = 1'b0;
        drain(20, "single");
        repeat (3) step();
        chk("single_vld_cycles", 32'(vld_cnt), 32'd1);
        chk("single_reads", 32'(acc_cnt), 32'd1);
        chk("single_latency", 32'(first_pop - first_acc), 32'd2);

        // Full-rate stream of 0..999.
        do_reset("pre_stream");
        clear_stats();
        for (int i = 0; i < 1000; i++) fifo_q.push_back(32'(i));
        fifo_empty = 1'b0;
        drain(1100, "stream");
        chk("stream_beats", 32'(pop_cnt), 32'd1000);
        chk("stream_span", 32'(last_pop - first_pop), 32'd999);
        chk("stream_fill", 32'(first_pop - first_acc), 32'd2);

        // Stall with tready low: only two reads may be outstanding.
        clear_stats();
        for (int i = 0; i < 5; i++) fifo_q.push_back(32'h5000 + 32'(i));
        fifo_empty    = 1'b0;
        ready_prob    = 0;
        m_axis_tready = 1'b0;
        repeat (10) step();
        chk("stall_reads", 32'(acc_cnt), 32'd2);
        ready_prob = 100;
        drain(50, "stall");

        // Random upstream gaps and random backpressure.
        clear_stats();
        src_left   = 500;
        push_prob  = 70;
        ready_prob = 50;
        drain(5000, "bp");
        chk("bp_beats", 32'(pop_cnt), 32'd500);
        push_prob  = 100;
        ready_prob = 100;

        // Reset while the second beat of a packet is on the bus.
        do_reset("pre_mid");
        clear_stats();
        for (int i = 0; i < 20; i++) fifo_q.push_back(32'h100 + 32'(i));
        fifo_empty = 1'b0;
        for (int n = 0; n < 20 && beats < 1; n++) step();
        chk("mid_beat2_vld", {31'd0, vld4}, 32'd1);
        do_reset("mid");
        drain(100, "post_mid");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
